// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: architectural PC, single-outstanding instruction fetch, retired count.
// Latency: fetched word visible the cycle after imem_ready; at least 2 cycles per instruction.
// Backpressure: imem_ready low holds FETCH with a stable address; retire low holds the instruction.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  next_pc_select,
   input  logic [31:0] immediate,
   input  logic [31:0] rs1_data,
   input  logic        retire,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus_4,
   output logic        misaligned_target,
   output logic [63:0] instret
);

   localparam logic [1:0] CTL_PC_PC4     = 2'b00;
   localparam logic [1:0] CTL_PC_PC_IMM  = 2'b01;
   localparam logic [1:0] CTL_PC_RS1_IMM = 2'b10;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_HOLD  = 2'b01,
      ST_HALT  = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_valid_q, inst_valid_d;
   logic        misaligned_q, misaligned_d;
   logic [63:0] instret_q, instret_d;

   logic [31:0] seq_pc;
   logic [31:0] target;
   logic        target_aligned;
   logic        fetch_done;
   logic        retiring;

   // Link value and fall-through address share one adder.
   assign seq_pc = pc_q + 32'd4;

   // Control-transfer target; the reserved select falls back to sequential flow.
   always_comb begin
      target = seq_pc;
      case (next_pc_select)
         CTL_PC_PC4:     target = seq_pc;
         CTL_PC_PC_IMM:  target = pc_q + immediate;
         CTL_PC_RS1_IMM: target = (rs1_data + immediate) & ~32'h1;
         default:        target = seq_pc;
      endcase
   end

   assign target_aligned = (target[1:0] == 2'b00);
   assign fetch_done     = (state_q == ST_FETCH) && imem_ready;
   assign retiring       = (state_q == ST_HOLD) && retire;

   // Next-state and next-value computation for every architectural register.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      misaligned_d = misaligned_q;
      instret_d    = instret_q;
      case (state_q)
         ST_FETCH: begin
            if (fetch_done) begin
               inst_d       = imem_rdata;
               inst_valid_d = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (retiring) begin
               inst_valid_d = 1'b0;
               if (target_aligned) begin
                  pc_d      = target;
                  instret_d = instret_q + 64'd1;
                  state_d   = ST_FETCH;
               end else begin
                  // Faulting transfer: freeze PC and count, stop fetching until reset.
                  misaligned_d = 1'b1;
                  state_d      = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            inst_valid_d = 1'b0;
         end
         default: begin
            inst_valid_d = 1'b0;
            state_d      = ST_HALT;
         end
      endcase
   end

   // State and architectural registers; reset is asynchronous, active-low.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         inst_q       <= 32'h0;
         inst_valid_q <= 1'b0;
         misaligned_q <= 1'b0;
         instret_q    <= 64'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         misaligned_q <= misaligned_d;
         instret_q    <= instret_d;
      end
   end

   // Request depends only on state and reset, so it drops the instant reset asserts.
   assign imem_req          = (state_q == ST_FETCH) && reset;
   assign imem_addr         = pc_q;
   assign inst              = inst_q;
   assign inst_valid        = inst_valid_q;
   assign pc                = pc_q;
   assign pc_plus_4         = seq_pc;
   assign misaligned_target = misaligned_q;
   assign instret           = instret_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus randomized traffic against a behavioural model.
// The model tracks the PC as a number and the fetch as "waiting / holding / halted" flags.
// All checks happen 1 time unit after the rising edge; inputs change there too.
module tb_fetch_pc_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  next_pc_select = 2'b00;
   logic [31:0] immediate = 32'h0;
   logic [31:0] rs1_data = 32'h0;
   logic        retire = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus_4;
   logic        misaligned_target;
   logic [63:0] instret;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic        m_have;
   logic        m_halt;
   logic        m_mis;
   logic [63:0] m_instret;

   fetch_pc_unit dut (
      .clock(clock), .reset(reset), .next_pc_select(next_pc_select),
      .immediate(immediate), .rs1_data(rs1_data), .retire(retire),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid), .pc(pc),
      .pc_plus_4(pc_plus_4), .misaligned_target(misaligned_target), .instret(instret)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      m_pc = 32'h0040_0000; m_inst = 32'h0; m_have = 1'b0;
      m_halt = 1'b0; m_mis = 1'b0; m_instret = 64'h0;
   endtask

   // One clock edge: the model consumes the inputs present at the edge.
   task automatic tick();
      logic [31:0] t;
      logic [31:0] n_pc, n_inst;
      logic        n_have, n_halt, n_mis;
      logic [63:0] n_ret;
      n_pc = m_pc; n_inst = m_inst; n_have = m_have; n_halt = m_halt;
      n_mis = m_mis; n_ret = m_instret;
      if (reset && !m_halt) begin
         if (!m_have) begin
            if (imem_ready) begin n_inst = imem_rdata; n_have = 1'b1; end
         end else if (retire) begin
            if (next_pc_select == 2'd1)      t = m_pc + immediate;
            else if (next_pc_select == 2'd2) t = (rs1_data + immediate) & 32'hFFFF_FFFE;
            else                             t = m_pc + 32'd4;
            n_have = 1'b0;
            if (t % 4 == 0) begin n_pc = t; n_ret = m_instret + 64'd1; end
            else begin n_mis = 1'b1; n_halt = 1'b1; end
         end
      end
      @(posedge clock);
      m_pc = n_pc; m_inst = n_inst; m_have = n_have; m_halt = n_halt;
      m_mis = n_mis; m_instret = n_ret;
      #1;
   endtask

   task automatic test_reset();
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; retire = 1'b1;
      model_reset();
      tick(); tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      checks++; if (pc !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc: got %h want 00400000", pc); end
      checks++; if (inst !== 32'h0 || inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst: got %h/%b want 0/0", inst, inst_valid); end
      checks++; if (misaligned_target !== 1'b0 || instret !== 64'h0) begin errors++; $display("FAIL reset_mis_ret: got %b/%h want 0/0", misaligned_target, instret); end
      @(negedge clock);
      reset = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL release_req: got %b/%h want 1/00400000", imem_req, imem_addr); end
   endtask

   task automatic test_sequential();
      imem_ready = 1'b1; imem_rdata = 32'h0000_0013; retire = 1'b1; next_pc_select = 2'b00;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 + 32'(4 * i)) begin
            errors++; $display("FAIL seq_addr[%0d]: got %b/%h want 1/%h", i, imem_req, imem_addr, 32'h0040_0000 + 32'(4 * i));
         end
         tick();
         checks++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0000_0013 || instret !== 64'(i)) begin
            errors++; $display("FAIL seq_hold[%0d]: req=%b v=%b inst=%h ret=%0d want 0/1/00000013/%0d", i, imem_req, inst_valid, inst, instret, i);
         end
         tick();
         checks++;
         if (instret !== 64'(i + 1)) begin errors++; $display("FAIL seq_instret[%0d]: got %0d want %0d", i, instret, i + 1); end
      end
   endtask

   task automatic test_branch();
      retire = 1'b0; imem_ready = 1'b1;
      tick();
      checks++; if (pc !== 32'h0040_0010 || pc_plus_4 !== 32'h0040_0014) begin errors++; $display("FAIL br_link: got %h/%h want 00400010/00400014", pc, pc_plus_4); end
      next_pc_select = 2'b01; immediate = 32'hFFFF_FFF0; retire = 1'b1;
      tick();
      checks++; if (imem_addr !== 32'h0040_0000 || imem_req !== 1'b1 || inst_valid !== 1'b0) begin errors++; $display("FAIL br_target: got %h/%b/%b want 00400000/1/0", imem_addr, imem_req, inst_valid); end
      checks++; if (instret !== m_instret) begin errors++; $display("FAIL br_instret: got %0d want %0d", instret, m_instret); end
   endtask

   task automatic test_jalr();
      retire = 1'b0; tick();
      next_pc_select = 2'b10; rs1_data = 32'h0040_1001; immediate = 32'd4; retire = 1'b1;
      tick();
      checks++; if (pc !== 32'h0040_1004 || misaligned_target !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL jalr: got %h/%b/%b want 00401004/0/1", pc, misaligned_target, imem_req); end
   endtask

   task automatic test_wait_states();
      logic [31:0] a0, word;
      logic [63:0] r0;
      a0 = pc; r0 = instret; word = $urandom;
      imem_ready = 1'b0; retire = 1'b1; next_pc_select = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (imem_addr !== a0 || imem_req !== 1'b1 || inst_valid !== 1'b0 || instret !== r0) begin
            errors++; $display("FAIL wait[%0d]: addr=%h req=%b v=%b ret=%0d want %h/1/0/%0d", i, imem_addr, imem_req, inst_valid, instret, a0, r0);
         end
      end
      imem_ready = 1'b1; imem_rdata = word; retire = 1'b0;
      checks++; if (imem_addr !== a0 || inst_valid !== 1'b0) begin errors++; $display("FAIL wait_ready_cycle: got %h/%b want %h/0", imem_addr, inst_valid, a0); end
      tick();
      imem_ready = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst !== word) begin errors++; $display("FAIL wait_valid: got %b/%h want 1/%h", inst_valid, inst, word); end
      retire = 1'b1;
      tick();
      checks++; if (pc !== a0 + 32'd4 || instret !== r0 + 64'd1) begin errors++; $display("FAIL wait_retire: got %h/%0d want %h/%0d", pc, instret, a0 + 32'd4, r0 + 64'd1); end
   endtask

   task automatic test_wrap();
      imem_ready = 1'b1; retire = 1'b0; tick();
      next_pc_select = 2'b10; rs1_data = 32'hFFFF_FFF8; immediate = 32'd4; retire = 1'b1;
      tick();
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h want fffffffc", pc); end
      retire = 1'b0; tick();
      checks++; if (pc_plus_4 !== 32'h0) begin errors++; $display("FAIL wrap_link: got %h want 00000000", pc_plus_4); end
      next_pc_select = 2'b00; retire = 1'b1;
      tick();
      checks++; if (pc !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h/%h want 0/0", pc, imem_addr); end
   endtask

   task automatic test_misaligned();
      logic [31:0] p0;
      logic [63:0] r0;
      imem_ready = 1'b1; retire = 1'b0; tick();
      p0 = pc; r0 = instret;
      next_pc_select = 2'b01; immediate = 32'd6; retire = 1'b1;
      tick();
      checks++; if (misaligned_target !== 1'b1 || pc !== p0 || instret !== r0) begin errors++; $display("FAIL mis_trap: got %b/%h/%0d want 1/%h/%0d", misaligned_target, pc, instret, p0, r0); end
      checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mis_halt: got %b/%b want 0/0", imem_req, inst_valid); end
      for (int i = 0; i < 4; i++) begin
         retire = i[0]; next_pc_select = 2'b00;
         tick();
         checks++;
         if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== p0 || misaligned_target !== 1'b1) begin
            errors++; $display("FAIL mis_stuck[%0d]: req=%b v=%b pc=%h mis=%b want 0/0/%h/1", i, imem_req, inst_valid, pc, misaligned_target, p0);
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      reset = 1'b0; #1; model_reset(); tick(); reset = 1'b1;
      imem_ready = 1'b1; retire = 1'b1; next_pc_select = 2'b00;
      tick(); tick();
      imem_ready = 1'b0;
      tick();
      checks++; if (imem_req !== 1'b1 || pc !== 32'h0040_0004) begin errors++; $display("FAIL midrst_pre: got %b/%h want 1/00400004", imem_req, pc); end
      #2 reset = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", imem_req); end
      model_reset();
      imem_ready = 1'b1;
      tick(); tick();
      reset = 1'b1;
      #1;
      checks++; if (pc !== 32'h0040_0000 || instret !== 64'h0 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
         errors++; $display("FAIL midrst_post: pc=%h ret=%0d v=%b req=%b want 00400000/0/0/1", pc, instret, inst_valid, imem_req);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         imem_ready = ($urandom_range(9) < 7);
         imem_rdata = $urandom;
         retire = ($urandom_range(3) != 0);
         next_pc_select = 2'($urandom_range(3));
         rs1_data = $urandom;
         if ($urandom_range(19) == 0) immediate = $urandom;
         else immediate = {{20{1'b0}}, 10'($urandom), 2'b00} - 32'd2048;
         tick();
         checks++;
         if (pc !== m_pc || imem_addr !== m_pc || pc_plus_4 !== m_pc + 32'd4 ||
             inst_valid !== m_have || inst !== m_inst || misaligned_target !== m_mis ||
             instret !== m_instret || imem_req !== (!m_halt && !m_have)) begin
            errors++;
            $display("FAIL random[%0d]: pc=%h v=%b inst=%h mis=%b ret=%0d req=%b want %h/%b/%h/%b/%0d/%b",
                     i, pc, inst_valid, inst, misaligned_target, instret, imem_req,
                     m_pc, m_have, m_inst, m_mis, m_instret, !m_halt && !m_have);
         end
         if (m_halt && $urandom_range(3) == 0) begin
            reset = 1'b0; #1; model_reset(); tick(); reset = 1'b1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jalr();
      test_wait_states();
      test_wrap();
      test_misaligned();
      test_reset_mid_fetch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
